// File: rtl/multicycle_control_if.sv
// Memory-side handshake bundle for the multi-cycle controller.
// The controller (master) issues requests and address select; memory (slave)
// answers with a single-cycle ready strobe.
interface multicycle_control_if;
  logic mem_req_o;
  logic mem_we_o;
  logic iord_o;
  logic mem_ready_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output iord_o,
    input  mem_ready_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  iord_o,
    output mem_ready_i
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the MIPS-subset core.
// Sequences fetch/decode/execute/memory/write-back and drives every datapath
// strobe. Outputs are Moore-decoded from the state register except the IR and
// PC write strobes in FETCH, which are qualified by memory ready.
module multicycle_control #(
  parameter int ALUOP_W = 3,
  parameter bit EN_ADDI = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          op_i,
  multicycle_control_if.master mem,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic [1:0]          pc_src_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALUOP_W-1:0]  alu_op_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                illegal_o,
  output logic [3:0]          state_o
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_R   = 2'b11;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;
  logic [1:0] aop;

  // State, latched opcode and sticky trap flag; reset clears all immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state selection and per-state strobe decode.
  always_comb begin
    state_d         = S_IDLE;
    op_d            = op_q;
    illegal_d       = illegal_q | (state_d == S_TRAP);
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.iord_o      = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 2'b00;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    aop             = ALU_ADD;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem.mem_req_o = 1'b1;
        alu_src_b_o   = 2'b01;
        ir_write_o    = mem.mem_ready_i;
        pc_write_o    = mem.mem_ready_i;
        state_d       = mem.mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        op_d        = op_i;
        case (op_i)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_ORI:       state_d = S_EXEC_I;
          OP_ADDI:      state_d = EN_ADDI ? S_EXEC_I : S_TRAP;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem.mem_req_o = 1'b1;
        mem.iord_o    = 1'b1;
        state_d       = mem.mem_ready_i ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        mem.mem_req_o = 1'b1;
        mem.mem_we_o  = 1'b1;
        mem.iord_o    = 1'b1;
        state_d       = mem.mem_ready_i ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        aop         = ALU_R;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        aop         = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        aop             = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 2'b01;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = 2'b10;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // Upper ALU-op bits are reserved and held at zero.
  always_comb begin
    alu_op_o      = '0;
    alu_op_o[1:0] = aop;
  end

  assign illegal_o = illegal_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: two instances (addi enabled and
// disabled); stimulus pushes hand-computed output vectors, a negedge monitor
// pops and compares them against each instance.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       req;
    logic       we;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] aop;
    logic       rd;
    logic       m2r;
    logic       rw;
  } exp_t;

  //                               st    ill   req   we    iord  irw   pcw   pcwc  pcs    sa    sb     aop     rd    m2r   rw
  localparam exp_t E_IDLE     = {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_FETCH_W  = {4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_FETCH_R  = {4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_DECODE   = {4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_MEM_ADDR = {4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_MEM_RD   = {4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_MEM_WB   = {4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1};
  localparam exp_t E_MEM_WR   = {4'd6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_EXEC_R   = {4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b011, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_R_WB     = {4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 1'b1};
  localparam exp_t E_EXEC_ORI = {4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_EXEC_ADD = {4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_I_WB     = {4'd10,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1};
  localparam exp_t E_BRANCH   = {4'd11,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_JUMP     = {4'd12,1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};
  localparam exp_t E_TRAP     = {4'd15,1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A: addi enabled ----------------
  logic       rst_a = 1'b0;
  logic [5:0] op_a  = 6'd0;
  multicycle_control_if ifa ();
  logic       a_irw, a_pcw, a_pcwc, a_sa, a_rd, a_m2r, a_rw, a_ill;
  logic [1:0] a_pcs, a_sb;
  logic [2:0] a_aop;
  logic [3:0] a_st;

  multicycle_control #(.ALUOP_W(3), .EN_ADDI(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .op_i(op_a), .mem(ifa.master),
    .ir_write_o(a_irw), .pc_write_o(a_pcw), .pc_write_cond_o(a_pcwc),
    .pc_src_o(a_pcs), .alu_src_a_o(a_sa), .alu_src_b_o(a_sb),
    .alu_op_o(a_aop), .reg_dst_o(a_rd), .mem_to_reg_o(a_m2r),
    .reg_write_o(a_rw), .illegal_o(a_ill), .state_o(a_st)
  );

  exp_t act_a;
  assign act_a = {a_st, a_ill, ifa.mem_req_o, ifa.mem_we_o, ifa.iord_o, a_irw, a_pcw, a_pcwc,
                  a_pcs, a_sa, a_sb, a_aop, a_rd, a_m2r, a_rw};

  // ---------------- instance B: addi disabled ----------------
  logic       rst_b = 1'b0;
  logic [5:0] op_b  = 6'd0;
  multicycle_control_if ifb ();
  logic       b_irw, b_pcw, b_pcwc, b_sa, b_rd, b_m2r, b_rw, b_ill;
  logic [1:0] b_pcs, b_sb;
  logic [2:0] b_aop;
  logic [3:0] b_st;

  multicycle_control #(.ALUOP_W(3), .EN_ADDI(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .op_i(op_b), .mem(ifb.master),
    .ir_write_o(b_irw), .pc_write_o(b_pcw), .pc_write_cond_o(b_pcwc),
    .pc_src_o(b_pcs), .alu_src_a_o(b_sa), .alu_src_b_o(b_sb),
    .alu_op_o(b_aop), .reg_dst_o(b_rd), .mem_to_reg_o(b_m2r),
    .reg_write_o(b_rw), .illegal_o(b_ill), .state_o(b_st)
  );

  exp_t act_b;
  assign act_b = {b_st, b_ill, ifb.mem_req_o, ifb.mem_we_o, ifb.iord_o, b_irw, b_pcw, b_pcwc,
                  b_pcs, b_sa, b_sb, b_aop, b_rd, b_m2r, b_rw};

  // ---------------- scoreboard ----------------
  exp_t  qa[$];
  string na[$];
  exp_t  qb[$];
  string nb[$];

  // Drive one cycle of inputs for the selected instance and record what it
  // must present during that cycle.
  task automatic step(input int sel, input logic rst, input logic [5:0] op,
                      input logic rdy, input exp_t e, input string name);
    if (sel == 0) begin
      rst_a = rst; op_a = op; ifa.mem_ready_i = rdy;
      qa.push_back(e); na.push_back(name);
    end else begin
      rst_b = rst; op_b = op; ifb.mem_ready_i = rdy;
      qb.push_back(e); nb.push_back(name);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each instance mid-cycle against the pending expectation.
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      exp_t e;
      string n;
      e = qa.pop_front();
      n = na.pop_front();
      total++;
      if (act_a !== e) begin
        bad++;
        $display("FAIL A:%s actual=%h required=%h (state %0d vs %0d)", n, act_a, e, act_a.st, e.st);
      end
    end
    if (qb.size() > 0) begin
      exp_t e;
      string n;
      e = qb.pop_front();
      n = nb.pop_front();
      total++;
      if (act_b !== e) begin
        bad++;
        $display("FAIL B:%s actual=%h required=%h (state %0d vs %0d)", n, act_b, e, act_b.st, e.st);
      end
    end
  end

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, ORI = 6'b001101,
                         ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010, JUNK = 6'b111111;

  initial begin
    ifa.mem_ready_i = 1'b1;
    ifb.mem_ready_i = 1'b1;
    @(posedge clk);
    #1;

    // Reset, then R-type: 0,1,2,7,8,1
    step(0, 1'b0, R, 1'b1, E_IDLE,    "reset0");
    step(0, 1'b0, R, 1'b1, E_IDLE,    "reset1");
    step(0, 1'b1, R, 1'b1, E_IDLE,    "r_idle");
    step(0, 1'b1, R, 1'b1, E_FETCH_R, "r_fetch");
    step(0, 1'b1, R, 1'b1, E_DECODE,  "r_decode");
    step(0, 1'b1, JUNK, 1'b1, E_EXEC_R, "r_exec");
    step(0, 1'b1, JUNK, 1'b1, E_R_WB,   "r_wb");

    // FETCH with two wait cycles, then lw with three MEM_RD wait cycles
    step(0, 1'b1, JUNK, 1'b0, E_FETCH_W, "lw_fetch_w0");
    step(0, 1'b1, JUNK, 1'b0, E_FETCH_W, "lw_fetch_w1");
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "lw_fetch_r");
    step(0, 1'b1, LW,   1'b0, E_DECODE,  "lw_decode");
    step(0, 1'b1, SW,   1'b1, E_MEM_ADDR,"lw_addr");
    step(0, 1'b1, SW,   1'b0, E_MEM_RD,  "lw_rd_w0");
    step(0, 1'b1, SW,   1'b0, E_MEM_RD,  "lw_rd_w1");
    step(0, 1'b1, SW,   1'b0, E_MEM_RD,  "lw_rd_w2");
    step(0, 1'b1, SW,   1'b1, E_MEM_RD,  "lw_rd_r");
    step(0, 1'b1, SW,   1'b1, E_MEM_WB,  "lw_wb");

    // sw
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "sw_fetch");
    step(0, 1'b1, SW,   1'b1, E_DECODE,  "sw_decode");
    step(0, 1'b1, LW,   1'b1, E_MEM_ADDR,"sw_addr");
    step(0, 1'b1, LW,   1'b1, E_MEM_WR,  "sw_wr");

    // ori then addi
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "ori_fetch");
    step(0, 1'b1, ORI,  1'b1, E_DECODE,  "ori_decode");
    step(0, 1'b1, ADDI, 1'b1, E_EXEC_ORI,"ori_exec");
    step(0, 1'b1, ADDI, 1'b1, E_I_WB,    "ori_wb");
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "addi_fetch");
    step(0, 1'b1, ADDI, 1'b1, E_DECODE,  "addi_decode");
    step(0, 1'b1, ORI,  1'b1, E_EXEC_ADD,"addi_exec");
    step(0, 1'b1, ORI,  1'b1, E_I_WB,    "addi_wb");

    // beq then j
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "beq_fetch");
    step(0, 1'b1, BEQ,  1'b1, E_DECODE,  "beq_decode");
    step(0, 1'b1, JUNK, 1'b1, E_BRANCH,  "beq_branch");
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "j_fetch");
    step(0, 1'b1, J,    1'b1, E_DECODE,  "j_decode");
    step(0, 1'b1, JUNK, 1'b1, E_JUMP,    "j_jump");

    // Reset pulsed while a store is waiting in MEM_WR
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "rst_fetch");
    step(0, 1'b1, SW,   1'b1, E_DECODE,  "rst_decode");
    step(0, 1'b1, JUNK, 1'b0, E_MEM_ADDR,"rst_addr");
    step(0, 1'b1, JUNK, 1'b0, E_MEM_WR,  "rst_memwr");
    step(0, 1'b0, JUNK, 1'b1, E_IDLE,    "rst_mid");
    step(0, 1'b1, JUNK, 1'b1, E_IDLE,    "rst_release");
    step(0, 1'b1, JUNK, 1'b1, E_FETCH_R, "rst_refetch");

    // Illegal opcode traps and stays trapped
    step(0, 1'b1, 6'b111000, 1'b1, E_DECODE, "ill_decode");
    step(0, 1'b1, R,    1'b1, E_TRAP,    "ill_trap0");
    step(0, 1'b1, J,    1'b1, E_TRAP,    "ill_trap1");
    step(0, 1'b1, R,    1'b1, E_TRAP,    "ill_trap2");
    step(0, 1'b0, R,    1'b1, E_IDLE,    "ill_reset");

    // Instance B: addi disabled traps; ori still executes
    step(1, 1'b1, JUNK, 1'b1, E_IDLE,    "b_idle");
    step(1, 1'b1, JUNK, 1'b1, E_FETCH_R, "b_addi_fetch");
    step(1, 1'b1, ADDI, 1'b1, E_DECODE,  "b_addi_decode");
    step(1, 1'b1, ORI,  1'b1, E_TRAP,    "b_trap0");
    step(1, 1'b1, R,    1'b1, E_TRAP,    "b_trap1");
    step(1, 1'b1, R,    1'b1, E_TRAP,    "b_trap2");
    step(1, 1'b0, R,    1'b1, E_IDLE,    "b_reset");
    step(1, 1'b1, R,    1'b1, E_IDLE,    "b_release");
    step(1, 1'b1, JUNK, 1'b1, E_FETCH_R, "b_ori_fetch");
    step(1, 1'b1, ORI,  1'b1, E_DECODE,  "b_ori_decode");
    step(1, 1'b1, JUNK, 1'b1, E_EXEC_ORI,"b_ori_exec");
    step(1, 1'b1, JUNK, 1'b1, E_I_WB,    "b_ori_wb");

    @(posedge clk);
    #1;
    total++;
    if ((qa.size() + qb.size()) != 0) begin
      bad++;
      $display("FAIL drain actual=%0d pending required=0", qa.size() + qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control FSM for the MIPS-subset CPU; the sequential successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states and drives every datapath control strobe. Memory accesses use a ready handshake so the core tolerates variable-latency memory. ALU-op width and `addi` support are parametrised, and illegal opcodes trap.

## Interface
- `ALUOP_W`, default 3: width of `alu_op_o`; minimum 2. Bits above [1:0] are driven 0.
- `EN_ADDI`, default 1: 1 = `addi` (op 6'b001000) supported; 0 = `addi` decodes as illegal.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `op_i` in 6: instruction opcode from the IR; sampled only in DECODE.
- `mem_ready_i` in 1: memory completes the current request this cycle.
- `mem_req_o` out 1: memory request (FETCH, MEM_RD, MEM_WR).
- `mem_we_o` out 1: memory write.
- `iord_o` out 1: address select; 0 = PC, 1 = ALUOut.
- `ir_write_o` out 1: load IR.
- `pc_write_o` out 1: unconditional PC write.
- `pc_write_cond_o` out 1: PC write if ALU zero.
- `pc_src_o` out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- `alu_src_a_o` out 1: 0 = PC, 1 = rs.
- `alu_src_b_o` out 2: 00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- `alu_op_o` out ALUOP_W: [1:0] 00 = add, 01 = sub, 10 = or, 11 = R-type (funct decode).
- `reg_dst_o` out 1: 1 = rd, 0 = rt.
- `mem_to_reg_o` out 1: 1 = MDR, 0 = ALUOut.
- `reg_write_o` out 1: register-file write.
- `illegal_o` out 1: sticky illegal-opcode flag.
- `state_o` out 4: current state encoding, for debug.

## Operation
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, R_WB 8, EXEC_I 9, I_WB 10, BRANCH 11, JUMP 12, TRAP 15. All other codes go to IDLE.
- Every output not listed for a state is 0.
- **IDLE**: all outputs 0. Next state: FETCH.
- **FETCH**:
  - Drives `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=add, `pc_src`=00.
  - `ir_write_o` and `pc_write_o` equal `mem_ready_i` (Mealy qualification).
  - Stays in FETCH until `mem_ready_i`=1, then goes to DECODE.
- **DECODE**:
  - Drives `alu_src_a`=0, `alu_src_b`=11, `alu_op`=add (branch target).
  - Captures `op_i` into internal `op_q`.
  - Next state by opcode:
    - 000000 → EXEC_R.
    - 100011 (lw) or 101011 (sw) → MEM_ADDR.
    - 001101 (ori) → EXEC_I.
    - 001000 (addi, only if EN_ADDI) → EXEC_I.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - Anything else → TRAP.
- **MEM_ADDR**: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=add. Next: MEM_RD if `op_q` is lw, MEM_WR if sw.
- **MEM_RD**: `mem_req`=1, `iord`=1. Waits for `mem_ready_i`, then goes to MEM_WB.
- **MEM_WB**: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next: FETCH.
- **MEM_WR**: `mem_req`=1, `mem_we`=1, `iord`=1. Waits for `mem_ready_i`, then goes to FETCH.
- **EXEC_R**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=11. Next: R_WB.
- **R_WB**: `reg_write`=1, `reg_dst`=1. Next: FETCH.
- **EXEC_I**: `alu_src_a`=1, `alu_src_b`=10; `alu_op`=or for ori, add for addi. Next: I_WB.
- **I_WB**: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Next: FETCH.
- **BRANCH**: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=sub, `pc_write_cond`=1, `pc_src`=01. Next: FETCH.
- **JUMP**: `pc_write`=1, `pc_src`=10. Next: FETCH.
- **TRAP**: all strobes 0, `illegal_o`=1. Stays in TRAP until reset.

## Timing
- Reset (`rst_i`=0), asynchronous:
  - State becomes IDLE, `op_q` becomes 0, `illegal_o` becomes 0.
  - All outputs read 0 while `rst_i` is low; `state_o` reads 0.
- Reset asserted mid-instruction: same result immediately, with no completion of a pending memory request. `mem_req_o` drops asynchronously.
- After `rst_i` deasserts, the first edge enters FETCH.
- All outputs except `ir_write_o`/`pc_write_o` in FETCH are Moore, decoded from the state register.
- `mem_ready_i` is honoured only in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.
- `op_i` is ignored outside DECODE. Changing `op_i` mid-instruction has no effect.
- Cycles per instruction with zero wait (`mem_ready_i` tied 1):
  - j and beq: 3.
  - R-type, ori, addi, sw: 4.
  - lw: 5.
  - Each wait cycle adds 1.

## Test plan
- Reset, then `mem_ready_i`=1, `op_i`=000000 → state sequence 0,1,2,7,8,1. `reg_write_o`=1 and `reg_dst_o`=1 only in state 8. `alu_op_o`=3'b011 in state 7.
- lw with `mem_ready_i` held 0 for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles with `mem_req_o`=1 and `iord_o`=1. Then MEM_WB with `mem_to_reg_o`=1. Total 8 cycles from FETCH.
- FETCH with ready low for 2 cycles → `ir_write_o`/`pc_write_o` stay 0, then pulse 1 in the ready cycle only.
- ori versus addi (EN_ADDI=1) → `alu_op_o` = 3'b010 versus 3'b000 in EXEC_I. Repeat with EN_ADDI=0: addi → TRAP, `illegal_o`=1 stays high until reset.
- beq then j → BRANCH: `pc_write_cond_o`=1, `pc_src_o`=01, `alu_op_o`=001. JUMP: `pc_write_o`=1, `pc_src_o`=10.
- `rst_i` pulsed low during MEM_WR with `mem_req_o`=1 → `mem_req_o` and `mem_we_o` fall before the next clock edge. `state_o`=0, and FETCH follows on the first edge after release.
